// File: rtl/ncc_peak_tracker.sv
// ncc_peak_tracker
//   Sums the NUM_ROWS signed row accumulators of each window position into
//   one correlation score. Over a raster scan of POS_X*POS_Y positions it
//   keeps the highest score and the (x,y) where that score occurred. The
//   peak is then offered to the controller on a valid/ready handshake.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start           pulse: begins a new search (in IDLE), restarts it (in SCAN)
//   acc_valid       acc_in holds one position's row sums
//   acc_in          NUM_ROWS signed row accumulators, ACC_W bits each
//   busy            high while in SCAN, including while the pipeline drains
//   result_valid    peak result available (state REPORT)
//   result_ready    consumer accepts the result
//   best_score      signed peak score (running best during SCAN)
//   best_x, best_y  position of the peak
//   overflow        sticky: acc_valid arrived and was not accepted
//   dbg_state       current FSM state (0 IDLE, 1 SCAN, 2 REPORT)
//
// Handshake: the result moves on any clock edge where result_valid and
// result_ready are both high. result_valid does not depend on result_ready.
// best_* stay constant while result_valid is high and until the next start.
// acc_valid has no ready; a position offered when it cannot be taken is
// dropped and overflow is raised.
module ncc_peak_tracker #(
  parameter int NUM_ROWS = 16,
  parameter int ACC_W    = 8,
  parameter int POS_X    = 32,
  parameter int POS_Y    = 32,
  localparam int SUM_W   = ACC_W + $clog2(NUM_ROWS),
  localparam int XW      = $clog2(POS_X),
  localparam int YW      = $clog2(POS_Y)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           acc_valid,
  input  logic [NUM_ROWS-1:0][ACC_W-1:0] acc_in,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic signed [SUM_W-1:0]        best_score,
  output logic [XW-1:0]                  best_x,
  output logic [YW-1:0]                  best_y,
  output logic                           overflow,
  output logic [1:0]                     dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0]           x_cnt;
  logic [YW-1:0]           y_cnt;
  logic                    scan_done;   // final position already sampled
  logic                    s1_valid;
  logic                    s1_last;
  logic signed [SUM_W-1:0] s1_sum;
  logic [XW-1:0]           s1_x;
  logic [YW-1:0]           s1_y;
  logic                    s2_last;     // final position has passed the compare
  logic signed [SUM_W-1:0] row_sum;

  logic clear;
  logic accept;
  logic drop;
  logic at_last_x;
  logic at_last_pos;

  // A start in IDLE launches a search, a start in SCAN restarts it; both
  // wipe the same state. A start in REPORT does nothing.
  assign clear       = start && (state == ST_IDLE || state == ST_SCAN);
  assign accept      = acc_valid && state == ST_SCAN && !start && !scan_done;
  assign drop        = acc_valid && (state == ST_REPORT ||
                                     (state == ST_SCAN && scan_done && !start));
  assign at_last_x   = (x_cnt == XW'(POS_X - 1));
  assign at_last_pos = at_last_x && (y_cnt == YW'(POS_Y - 1));

  // Sign-extended sum of all rows; SUM_W leaves room for the worst case.
  always_comb begin
    row_sum = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      row_sum = row_sum + {{(SUM_W - ACC_W){acc_in[i][ACC_W-1]}}, acc_in[i]};
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SCAN;
      ST_SCAN:   if (!start && s2_last) state_nxt = ST_REPORT;
      ST_REPORT: if (result_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy         = (state == ST_SCAN);
    result_valid = (state == ST_REPORT);
    dbg_state    = state;
  end

  // Raster position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      scan_done <= 1'b0;
    end else if (clear) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      scan_done <= 1'b0;
    end else if (accept) begin
      if (at_last_x) begin
        x_cnt <= '0;
        y_cnt <= at_last_pos ? '0 : y_cnt + YW'(1);
      end else begin
        x_cnt <= x_cnt + XW'(1);
      end
      scan_done <= at_last_pos;
    end
  end

  // Stage 1: registered score with its position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum  <= row_sum;
        s1_x    <= x_cnt;
        s1_y    <= y_cnt;
        s1_last <= at_last_pos;
      end
    end
  end

  // Stage 2: running best. Strict compare keeps the earliest of equal scores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
      s2_last    <= 1'b0;
    end else if (clear) begin
      best_score <= {1'b1, {(SUM_W - 1){1'b0}}};
      best_x     <= '0;
      best_y     <= '0;
      s2_last    <= 1'b0;
    end else begin
      s2_last <= s1_valid && s1_last;
      if (s1_valid && s1_sum > best_score) begin
        best_score <= s1_sum;
        best_x     <= s1_x;
        best_y     <= s1_y;
      end
    end
  end

  // Sticky overflow, cleared only by a start that is acted upon
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        overflow <= 1'b0;
    else if (clear) overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

endmodule

// File: tb/tb_ncc_peak_tracker.sv
module tb_ncc_peak_tracker;

  localparam int NUM_ROWS = 16;
  localparam int ACC_W    = 8;
  localparam int POS_X    = 4;
  localparam int POS_Y    = 2;
  localparam int SUM_W    = ACC_W + $clog2(NUM_ROWS);
  localparam int XW       = $clog2(POS_X);
  localparam int YW       = $clog2(POS_Y);
  localparam int NPOS     = POS_X * POS_Y;
  localparam int W        = SUM_W + XW + YW;

  typedef logic [NUM_ROWS-1:0][ACC_W-1:0] rows_t;

  typedef struct {
    int r0[NPOS];   // row 0 value per position
    int rv[NPOS];   // value of every other row per position
    bit gaps;
    bit extra;      // acc_valid pulse after the final position, still in SCAN
    int hold;       // cycles result_ready is held low in REPORT
    bit start_ack;  // start together with the accepting handshake
    int exp_score;
    int exp_x;
    int exp_y;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic              acc_valid;
  rows_t             acc_in;
  logic              busy;
  logic              result_valid;
  logic              result_ready;
  logic [SUM_W-1:0]  best_score;
  logic [XW-1:0]     best_x;
  logic [YW-1:0]     best_y;
  logic              overflow;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  ncc_peak_tracker #(
    .NUM_ROWS(NUM_ROWS), .ACC_W(ACC_W), .POS_X(POS_X), .POS_Y(POS_Y)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .acc_valid(acc_valid), .acc_in(acc_in),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .best_score(best_score), .best_x(best_x), .best_y(best_y),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int score_of(input logic [SUM_W-1:0] s);
    return int'($signed(s));
  endfunction

  function automatic rows_t fill_rows(input int r0, input int rv);
    rows_t r;
    for (int i = 0; i < NUM_ROWS; i++) r[i] = ACC_W'(i == 0 ? r0 : rv);
    return r;
  endfunction

  // Reference: first position holding the maximum score, in raster order.
  function automatic logic [W-1:0] ref_best(input int scores[NPOS]);
    int bi;
    bi = 0;
    for (int i = 1; i < NPOS; i++) if (scores[i] > scores[bi]) bi = i;
    return {SUM_W'(scores[bi]), XW'(bi % POS_X), YW'(bi / POS_X)};
  endfunction

  function automatic logic [W-1:0] pack_exp(input int s, input int x, input int y);
    return {SUM_W'(s), XW'(x), YW'(y)};
  endfunction

  // driver tasks
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("overflow_after_start", overflow, 0);
    check("score_init_after_start", score_of(best_score), -(1 << (SUM_W - 1)));
  endtask

  task automatic send_rows(input rows_t rows, input bit gap);
    if (gap) begin
      acc_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    acc_in    = rows;
    acc_valid = 1'b1;
    tick();
  endtask

  // Called right after the edge that sampled the final position.
  task automatic finish_scan(input bit extra, input int hold, input bit start_ack);
    logic [W-1:0] e;
    int e_score, e_x, e_y, e_ovf;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    e_score = int'($signed(e[W-1:XW+YW]));
    e_x     = int'(e[XW+YW-1:YW]);
    e_y     = int'(e[YW-1:0]);
    e_ovf   = (extra || hold > 0) ? 1 : 0;
    acc_valid = 1'b0;
    check("rv_lat0", result_valid, 0);
    if (extra) begin
      acc_valid = 1'b1;
      acc_in    = fill_rows(127, 127);
    end
    tick();
    acc_valid = 1'b0;
    check("rv_lat1", result_valid, 0);
    check("busy_draining", busy, 1);
    tick();
    check("rv_lat2", result_valid, 1);
    check("busy_report", busy, 0);
    check("best_score", score_of(best_score), e_score);
    check("best_x", best_x, e_x);
    check("best_y", best_y, e_y);
    check("overflow_report", overflow, extra ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      if (h == 3) begin
        acc_valid = 1'b1;
        acc_in    = fill_rows(127, 127);
      end
      tick();
      acc_valid = 1'b0;
      check("hold_rv", result_valid, 1);
      check("hold_score", score_of(best_score), e_score);
      check("hold_x", best_x, e_x);
      check("hold_y", best_y, e_y);
    end
    check("overflow_before_ack", overflow, e_ovf);
    result_ready = 1'b1;
    start        = start_ack;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    check("rv_after_ack", result_valid, 0);
    check("busy_after_ack", busy, 0);
    check("state_idle_after_ack", dbg_state, 0);
    check("score_held_after_ack", score_of(best_score), e_score);
    check("overflow_after_ack", overflow, e_ovf);
  endtask

  task automatic run_vec(input vec_t v);
    do_start();
    for (int p = 0; p < NPOS; p++) send_rows(fill_rows(v.r0[p], v.rv[p]), v.gaps);
    exp_q.push_back(pack_exp(v.exp_score, v.exp_x, v.exp_y));
    finish_scan(v.extra, v.hold, v.start_ack);
  endtask

  vec_t vecs[5];

  initial begin
    int    scores[NPOS];
    int    sc;
    rows_t rows;
    vec_t  v_restart;

    // vector table
    vecs[0].r0 = '{1, 1, 1, 1, 1, 1, 3, 1};
    vecs[0].rv = '{1, 1, 1, 1, 1, 1, 3, 1};
    vecs[0].gaps = 0; vecs[0].extra = 1; vecs[0].hold = 0; vecs[0].start_ack = 1;
    vecs[0].exp_score = 48; vecs[0].exp_x = 2; vecs[0].exp_y = 1;

    vecs[1].r0 = '{-128, -128, -128, -128, -128, -128, -128, -128};
    vecs[1].rv = '{-128, -128, -128, -128, -128, -128, -128, -128};
    vecs[1].gaps = 0; vecs[1].extra = 0; vecs[1].hold = 10; vecs[1].start_ack = 0;
    vecs[1].exp_score = -2048; vecs[1].exp_x = 0; vecs[1].exp_y = 0;

    vecs[2].r0 = '{5, 9, 9, 3, 1, 2, 0, 4};
    vecs[2].rv = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].gaps = 0; vecs[2].extra = 0; vecs[2].hold = 0; vecs[2].start_ack = 0;
    vecs[2].exp_score = 9; vecs[2].exp_x = 1; vecs[2].exp_y = 0;

    vecs[3].r0 = '{0, 0, 0, 0, 0, 0, 0, 127};
    vecs[3].rv = '{0, 0, 0, 0, 0, 0, 0, 127};
    vecs[3].gaps = 1; vecs[3].extra = 0; vecs[3].hold = 0; vecs[3].start_ack = 0;
    vecs[3].exp_score = 2032; vecs[3].exp_x = 3; vecs[3].exp_y = 1;

    vecs[4].r0 = '{-3, -2, -7, -2, -9, -1, -1, -5};
    vecs[4].rv = '{-3, -2, -7, -2, -9, -1, -1, -5};
    vecs[4].gaps = 1; vecs[4].extra = 0; vecs[4].hold = 0; vecs[4].start_ack = 0;
    vecs[4].exp_score = -16; vecs[4].exp_x = 1; vecs[4].exp_y = 1;

    v_restart.r0 = '{3, 20, -4, 7, 0, 19, 20, 1};
    v_restart.rv = '{0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; acc_valid = 1'b0; result_ready = 1'b0;
    acc_in = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_score", score_of(best_score), 0);
    check("rst_x", best_x, 0);
    check("rst_y", best_y, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // acc_valid in IDLE is ignored
    acc_in = fill_rows(127, 127);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    check("idle_acc_overflow", overflow, 0);
    check("idle_acc_busy", busy, 0);

    // restart mid-scan with a coincident acc_valid
    do_start();
    for (int p = 0; p < 3; p++) send_rows(fill_rows(100, 100), 0);
    start     = 1'b1;
    acc_in    = fill_rows(127, 127);
    acc_valid = 1'b1;
    tick();
    start     = 1'b0;
    acc_valid = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_overflow", overflow, 0);
    tick();
    check("restart_score_cleared", score_of(best_score), -2048);
    for (int p = 0; p < NPOS; p++) send_rows(fill_rows(v_restart.r0[p], v_restart.rv[p]), 0);
    exp_q.push_back(pack_exp(20, 1, 0));
    finish_scan(0, 0, 0);

    // asynchronous reset mid-scan
    do_start();
    for (int p = 0; p < 3; p++) send_rows(fill_rows(50, 50), 0);
    acc_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rv", result_valid, 0);
    check("midrst_score", score_of(best_score), 0);
    check("midrst_x", best_x, 0);
    check("midrst_y", best_y, 0);
    check("midrst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec(vecs[0]);

    // randomized scans against the reference model
    for (int s = 0; s < 10; s++) begin
      do_start();
      for (int p = 0; p < NPOS; p++) begin
        sc = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
          if (s % 2 == 0) rows[i] = ACC_W'($urandom_range(0, 255));
          else            rows[i] = ACC_W'(int'($urandom_range(0, 2)) - 1);
          sc += int'($signed(rows[i]));
        end
        scores[p] = sc;
        send_rows(rows, s % 3 == 0);
      end
      exp_q.push_back(ref_best(scores));
      finish_scan(0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
